// File: rtl/axi_dma_burst_engine.sv
// DMA burst responder: turns one-cycle read/write commands into AXI4 INCR bursts
// on independent read and write channels, with done pulses and sticky error flags.
`timescale 1ns/1ps
module axi_dma_burst_engine #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int BIT_TRANS    = 18
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [BIT_TRANS-1:0]      i_num_trans,
    input  logic                      i_ctrl_read,
    input  logic [AXI_WIDTH_AD-1:0]   i_read_addr,
    output logic                      o_read_done,
    output logic [AXI_WIDTH_DA-1:0]   o_rd_data,
    output logic                      o_rd_valid,
    input  logic                      i_ctrl_write,
    input  logic [AXI_WIDTH_AD-1:0]   i_write_addr,
    input  logic [AXI_WIDTH_DA-1:0]   i_wr_data,
    output logic                      o_indata_req_wr,
    output logic                      o_write_done,
    output logic                      o_cmd_drop,
    output logic                      o_resp_err,
    input  logic                      i_clr_err,
    output logic [AXI_WIDTH_AD-1:0]   m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_WIDTH_DA-1:0]   m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic [AXI_WIDTH_AD-1:0]   m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [AXI_WIDTH_DA-1:0]   m_wdata,
    output logic [AXI_WIDTH_DA/8-1:0] m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
);

    localparam logic [2:0] C_SIZE       = 3'($clog2(AXI_WIDTH_DA/8));
    localparam logic [1:0] C_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_R    = 2'd2,
        RD_DONE = 2'd3
    } rd_state_t;

    typedef enum logic [2:0] {
        WR_IDLE = 3'd0,
        WR_AW   = 3'd1,
        WR_W    = 3'd2,
        WR_B    = 3'd3,
        WR_DONE = 3'd4
    } wr_state_t;

    rd_state_t               r_rd_state;
    logic [AXI_WIDTH_AD-1:0] r_araddr;
    logic [8:0]              r_rd_last_idx;
    logic [8:0]              r_rd_cnt;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_read_done;

    wr_state_t               r_wr_state;
    logic [AXI_WIDTH_AD-1:0] r_awaddr;
    logic [8:0]              r_wr_last_idx;
    logic [8:0]              r_wr_cnt;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_write_done;

    logic                    r_cmd_drop;
    logic                    r_resp_err;

    logic [8:0]              w_num_in;
    logic [8:0]              w_last_idx_in;
    logic                    w_rd_last;
    logic                    w_wr_last;
    logic                    w_rd_err;
    logic                    w_wr_err;
    logic                    w_drop;
    logic                    w_unused_num;

    // Beat counts above 256 are illegal, so only the low 9 bits are meaningful.
    assign w_num_in      = i_num_trans[8:0];
    assign w_last_idx_in = w_num_in - 9'd1;
    assign w_unused_num  = ^i_num_trans[BIT_TRANS-1:9];

    assign w_rd_last = (r_rd_cnt == r_rd_last_idx);
    assign w_wr_last = (r_wr_cnt == r_wr_last_idx);

    assign w_rd_err = (r_rd_state == RD_R) && m_rvalid &&
                      ((m_rresp != 2'b00) || (m_rlast != w_rd_last));
    assign w_wr_err = (r_wr_state == WR_B) && m_bvalid && (m_bresp != 2'b00);
    assign w_drop   = (i_ctrl_read  && (r_rd_state != RD_IDLE)) ||
                      (i_ctrl_write && (r_wr_state != WR_IDLE));

    // Read channel FSM: address phase, beat collection, then a one-cycle done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state    <= RD_IDLE;
            r_araddr      <= {AXI_WIDTH_AD{1'b0}};
            r_rd_last_idx <= 9'd0;
            r_rd_cnt      <= 9'd0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_read_done   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_read_done <= 1'b0;
                    if (i_ctrl_read) begin
                        r_araddr      <= i_read_addr;
                        r_rd_last_idx <= w_last_idx_in;
                        r_rd_cnt      <= 9'd0;
                        if (w_num_in == 9'd0) begin
                            r_read_done <= 1'b1;
                            r_rd_state  <= RD_DONE;
                        end else begin
                            r_arvalid  <= 1'b1;
                            r_rd_state <= RD_AR;
                        end
                    end
                end
                RD_AR: begin
                    if (m_arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_rd_state <= RD_R;
                    end
                end
                RD_R: begin
                    // The burst ends on our own count; rlast is only checked, never trusted.
                    if (m_rvalid) begin
                        r_rd_cnt <= r_rd_cnt + 9'd1;
                        if (w_rd_last) begin
                            r_rready    <= 1'b0;
                            r_read_done <= 1'b1;
                            r_rd_state  <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    r_read_done <= 1'b0;
                    r_rd_state  <= RD_IDLE;
                end
                default: begin
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_read_done <= 1'b0;
                    r_rd_state  <= RD_IDLE;
                end
            endcase
        end
    end

    // Write channel FSM: AW strictly before W, then wait for B and pulse done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state    <= WR_IDLE;
            r_awaddr      <= {AXI_WIDTH_AD{1'b0}};
            r_wr_last_idx <= 9'd0;
            r_wr_cnt      <= 9'd0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_write_done  <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    r_write_done <= 1'b0;
                    if (i_ctrl_write) begin
                        r_awaddr      <= i_write_addr;
                        r_wr_last_idx <= w_last_idx_in;
                        r_wr_cnt      <= 9'd0;
                        if (w_num_in == 9'd0) begin
                            r_write_done <= 1'b1;
                            r_wr_state   <= WR_DONE;
                        end else begin
                            r_awvalid  <= 1'b1;
                            r_wr_state <= WR_AW;
                        end
                    end
                end
                WR_AW: begin
                    if (m_awready) begin
                        r_awvalid  <= 1'b0;
                        r_wvalid   <= 1'b1;
                        r_wr_state <= WR_W;
                    end
                end
                WR_W: begin
                    if (m_wready) begin
                        r_wr_cnt <= r_wr_cnt + 9'd1;
                        if (w_wr_last) begin
                            r_wvalid   <= 1'b0;
                            r_bready   <= 1'b1;
                            r_wr_state <= WR_B;
                        end
                    end
                end
                WR_B: begin
                    if (m_bvalid) begin
                        r_bready     <= 1'b0;
                        r_write_done <= 1'b1;
                        r_wr_state   <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    r_write_done <= 1'b0;
                    r_wr_state   <= WR_IDLE;
                end
                default: begin
                    r_awvalid    <= 1'b0;
                    r_wvalid     <= 1'b0;
                    r_bready     <= 1'b0;
                    r_write_done <= 1'b0;
                    r_wr_state   <= WR_IDLE;
                end
            endcase
        end
    end

    // Sticky status flags; a fresh event in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd_drop <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_cmd_drop <= 1'b1;
            end else if (i_clr_err) begin
                r_cmd_drop <= 1'b0;
            end else begin
                r_cmd_drop <= r_cmd_drop;
            end
            if (w_rd_err || w_wr_err) begin
                r_resp_err <= 1'b1;
            end else if (i_clr_err) begin
                r_resp_err <= 1'b0;
            end else begin
                r_resp_err <= r_resp_err;
            end
        end
    end

    assign m_araddr  = r_araddr;
    assign m_arlen   = r_rd_last_idx[7:0];
    assign m_arsize  = C_SIZE;
    assign m_arburst = C_BURST_INCR;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

    assign m_awaddr  = r_awaddr;
    assign m_awlen   = r_wr_last_idx[7:0];
    assign m_awsize  = C_SIZE;
    assign m_awburst = C_BURST_INCR;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = i_wr_data;
    assign m_wstrb   = {(AXI_WIDTH_DA/8){1'b1}};
    assign m_wlast   = r_wvalid && w_wr_last;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;

    // Beat-level strobes follow the handshakes combinationally so the requester sees them in-cycle.
    assign o_rd_valid      = r_rready && m_rvalid;
    assign o_rd_data       = m_rdata;
    assign o_indata_req_wr = r_wvalid && m_wready;
    assign o_read_done     = r_read_done;
    assign o_write_done    = r_write_done;
    assign o_cmd_drop      = r_cmd_drop;
    assign o_resp_err      = r_resp_err;

endmodule

// File: tb/tb_axi_dma_burst_engine.sv
// Directed bench for axi_dma_burst_engine: the bench plays the AXI slave and the
// command requester, with expected values written out by hand.
`timescale 1ns/1ps
module tb_axi_dma_burst_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic [17:0] i_num_trans;
    logic        i_ctrl_read;
    logic [31:0] i_read_addr;
    logic        o_read_done;
    logic [31:0] o_rd_data;
    logic        o_rd_valid;
    logic        i_ctrl_write;
    logic [31:0] i_write_addr;
    logic [31:0] i_wr_data;
    logic        o_indata_req_wr;
    logic        o_write_done;
    logic        o_cmd_drop;
    logic        o_resp_err;
    logic        i_clr_err;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    int checks   = 0;
    int failures = 0;
    int rd_beats = 0;
    int wr_reqs  = 0;
    int rd_dones = 0;
    int wr_dones = 0;

    axi_dma_burst_engine #(.AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32), .BIT_TRANS(18)) dut (
        .clk(clk), .rstn(rstn), .i_num_trans(i_num_trans),
        .i_ctrl_read(i_ctrl_read), .i_read_addr(i_read_addr), .o_read_done(o_read_done),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_ctrl_write(i_ctrl_write), .i_write_addr(i_write_addr), .i_wr_data(i_wr_data),
        .o_indata_req_wr(o_indata_req_wr), .o_write_done(o_write_done),
        .o_cmd_drop(o_cmd_drop), .o_resp_err(o_resp_err), .i_clr_err(i_clr_err),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (o_rd_valid)      rd_beats <= rd_beats + 1;
            if (o_indata_req_wr) wr_reqs  <= wr_reqs + 1;
            if (o_read_done)     rd_dones <= rd_dones + 1;
            if (o_write_done)    wr_dones <= wr_dones + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_slave(input int ar_dly, input int nb, input int early,
                            input logic [1:0] resp, input bit bp,
                            input logic [31:0] ea, input logic [31:0] base);
        int n;
        n = 0;
        while (!m_arvalid && n < 20) begin
            tick();
            n++;
        end
        chk("ar_valid_seen", m_arvalid, 1'b1);
        if (!m_arvalid) return;
        for (int d = 0; d < ar_dly; d++) begin
            chk("ar_hold", m_arvalid, 1'b1);
            chk("ar_addr_stable", m_araddr, ea);
            tick();
        end
        chk("araddr", m_araddr, ea);
        chk("arlen", m_arlen, 8'(nb - 1));
        chk("arsize", m_arsize, 3'd2);
        chk("arburst", m_arburst, 2'b01);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (bp) begin
                m_rvalid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(i);
            m_rlast  = (i == nb - 1) || (i == early);
            m_rresp  = resp;
            #1;
            chk("rd_valid", o_rd_valid, 1'b1);
            chk("rd_data", o_rd_data, base + 32'(i));
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        chk("read_done_pulse", o_read_done, 1'b1);
        chk("rready_low", m_rready, 1'b0);
        tick();
        chk("read_done_single", o_read_done, 1'b0);
    endtask

    task automatic wr_slave(input int aw_dly, input int nb, input int mode,
                            input logic [1:0] resp, input bit clr_b, input int abort_at,
                            input logic [31:0] ea, input logic [31:0] base);
        int n;
        int k;
        n = 0;
        while (!m_awvalid && n < 20) begin
            tick();
            n++;
        end
        chk("aw_valid_seen", m_awvalid, 1'b1);
        if (!m_awvalid) return;
        for (int d = 0; d < aw_dly; d++) begin
            chk("aw_hold", m_awvalid, 1'b1);
            chk("w_before_aw", m_wvalid, 1'b0);
            tick();
        end
        chk("awaddr", m_awaddr, ea);
        chk("awlen", m_awlen, 8'(nb - 1));
        chk("awsize", m_awsize, 3'd2);
        chk("awburst", m_awburst, 2'b01);
        chk("w_before_aw_hs", m_wvalid, 1'b0);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        k = 0;
        n = 0;
        while (k < nb && n < 300) begin
            if (k == abort_at) return;
            case (mode)
                0:       m_wready = 1'b1;
                1:       m_wready = (n % 2 == 0);
                default: m_wready = 1'($urandom_range(0, 1));
            endcase
            i_wr_data = base + 32'(k);
            #1;
            if (m_wvalid && m_wready) begin
                chk("indata_req", o_indata_req_wr, 1'b1);
                chk("wdata", m_wdata, base + 32'(k));
                chk("wstrb", m_wstrb, 4'hF);
                chk("wlast", m_wlast, (k == nb - 1));
                k++;
            end else begin
                chk("indata_req_idle", o_indata_req_wr, 1'b0);
            end
            tick();
            n++;
        end
        m_wready = 1'b0;
        chk("w_beats_done", k, nb);
        chk("wvalid_low", m_wvalid, 1'b0);
        chk("bready", m_bready, 1'b1);
        tick();
        m_bvalid  = 1'b1;
        m_bresp   = resp;
        i_clr_err = clr_b;
        tick();
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        i_clr_err = 1'b0;
        chk("write_done_pulse", o_write_done, 1'b1);
        tick();
        chk("write_done_single", o_write_done, 1'b0);
    endtask

    task automatic clear_flags();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
    endtask

    int b0, d0, r0, e0;

    initial begin
        rstn = 1'b0;
        i_num_trans = 18'd0; i_ctrl_read = 1'b0; i_read_addr = 32'd0;
        i_ctrl_write = 1'b0; i_write_addr = 32'd0; i_wr_data = 32'd0; i_clr_err = 1'b0;
        m_arready = 1'b0; m_rdata = 32'd0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        repeat (3) tick();
        chk("rst_read_done", o_read_done, 1'b0);
        chk("rst_write_done", o_write_done, 1'b0);
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_awvalid", m_awvalid, 1'b0);
        chk("rst_wvalid", m_wvalid, 1'b0);
        chk("rst_rready", m_rready, 1'b0);
        chk("rst_bready", m_bready, 1'b0);
        chk("rst_cmd_drop", o_cmd_drop, 1'b0);
        chk("rst_resp_err", o_resp_err, 1'b0);
        rstn = 1'b1;
        tick();

        // Read 16 beats at 0x1000, arready delayed 3 cycles
        b0 = rd_beats; d0 = rd_dones;
        i_num_trans = 18'd16; i_read_addr = 32'h0000_1000; i_ctrl_read = 1'b1;
        tick();
        i_ctrl_read = 1'b0;
        rd_slave(3, 16, -1, 2'b00, 1'b0, 32'h0000_1000, 32'hA000_0000);
        chk("t1_beats", rd_beats - b0, 16);
        chk("t1_dones", rd_dones - d0, 1);

        // Zero-length read: straight to done, no AR
        i_num_trans = 18'd0; i_read_addr = 32'h0000_5000; i_ctrl_read = 1'b1;
        tick();
        i_ctrl_read = 1'b0;
        chk("zero_read_done", o_read_done, 1'b1);
        chk("zero_read_no_ar", m_arvalid, 1'b0);
        tick();
        chk("zero_read_done_end", o_read_done, 1'b0);
        chk("zero_read_no_ar2", m_arvalid, 1'b0);

        // Write 16 beats, wready toggling
        r0 = wr_reqs; e0 = wr_dones;
        i_num_trans = 18'd16; i_write_addr = 32'h0000_4000; i_ctrl_write = 1'b1;
        tick();
        i_ctrl_write = 1'b0;
        wr_slave(2, 16, 1, 2'b00, 1'b0, -1, 32'h0000_4000, 32'hB000_0000);
        chk("t2_reqs", wr_reqs - r0, 16);
        chk("t2_dones", wr_dones - e0, 1);

        // Simultaneous read and write commands with random back-pressure
        clear_flags();
        b0 = rd_beats; d0 = rd_dones; r0 = wr_reqs; e0 = wr_dones;
        i_num_trans = 18'd8;
        i_read_addr = 32'h0000_2000; i_write_addr = 32'h0000_3000;
        i_ctrl_read = 1'b1; i_ctrl_write = 1'b1;
        tick();
        i_ctrl_read = 1'b0; i_ctrl_write = 1'b0;
        fork
            rd_slave(2, 8, -1, 2'b00, 1'b1, 32'h0000_2000, 32'hC000_0000);
            wr_slave(1, 8, 2, 2'b00, 1'b0, -1, 32'h0000_3000, 32'hD000_0000);
        join
        chk("t3_rd_beats", rd_beats - b0, 8);
        chk("t3_wr_reqs", wr_reqs - r0, 8);
        chk("t3_rd_done", rd_dones - d0, 1);
        chk("t3_wr_done", wr_dones - e0, 1);
        chk("t3_no_drop", o_cmd_drop, 1'b0);

        // Second read command during R phase is dropped
        b0 = rd_beats; d0 = rd_dones;
        i_num_trans = 18'd8; i_read_addr = 32'h0000_3000; i_ctrl_read = 1'b1;
        tick();
        i_ctrl_read = 1'b0;
        fork
            rd_slave(0, 8, -1, 2'b00, 1'b1, 32'h0000_3000, 32'hE000_0000);
            begin
                for (int n = 0; n < 20 && !m_rready; n++) tick();
                chk("t4_in_r_phase", m_rready, 1'b1);
                i_num_trans = 18'd3; i_read_addr = 32'h0000_9990; i_ctrl_read = 1'b1;
                tick();
                i_ctrl_read = 1'b0;
                chk("t4_cmd_drop", o_cmd_drop, 1'b1);
            end
        join
        chk("t4_beats", rd_beats - b0, 8);
        chk("t4_dones", rd_dones - d0, 1);
        tick();
        chk("t4_no_second_ar", m_arvalid, 1'b0);
        chk("t4_drop_sticky", o_cmd_drop, 1'b1);
        clear_flags();
        chk("t4_drop_cleared", o_cmd_drop, 1'b0);

        // bresp error, with clear asserted in the same cycle as the error
        e0 = wr_dones;
        i_num_trans = 18'd4; i_write_addr = 32'h0000_5000; i_ctrl_write = 1'b1;
        tick();
        i_ctrl_write = 1'b0;
        wr_slave(0, 4, 0, 2'b10, 1'b1, -1, 32'h0000_5000, 32'h1100_0000);
        chk("t5_bresp_err", o_resp_err, 1'b1);
        chk("t5_wr_done", wr_dones - e0, 1);
        clear_flags();
        chk("t5_err_cleared", o_resp_err, 1'b0);

        // Early rlast on beat 3 of 8
        b0 = rd_beats; d0 = rd_dones;
        i_num_trans = 18'd8; i_read_addr = 32'h0000_6000; i_ctrl_read = 1'b1;
        tick();
        i_ctrl_read = 1'b0;
        rd_slave(0, 8, 2, 2'b00, 1'b0, 32'h0000_6000, 32'h2200_0000);
        chk("t5_rlast_err", o_resp_err, 1'b1);
        chk("t5_rd_beats", rd_beats - b0, 8);
        chk("t5_rd_done", rd_dones - d0, 1);
        clear_flags();
        chk("t5_err_cleared2", o_resp_err, 1'b0);

        // Reset in the middle of a write, after 5 of 16 beats
        r0 = wr_reqs;
        i_num_trans = 18'd16; i_write_addr = 32'h0000_7000; i_ctrl_write = 1'b1;
        tick();
        i_ctrl_write = 1'b0;
        wr_slave(0, 16, 0, 2'b00, 1'b0, 5, 32'h0000_7000, 32'h3300_0000);
        chk("t6_beats_before_rst", wr_reqs - r0, 5);
        chk("t6_wvalid_before_rst", m_wvalid, 1'b1);
        m_wready = 1'b0;
        rstn = 1'b0;
        #1;
        chk("t6_rst_wvalid", m_wvalid, 1'b0);
        chk("t6_rst_req", o_indata_req_wr, 1'b0);
        chk("t6_rst_awvalid", m_awvalid, 1'b0);
        chk("t6_rst_bready", m_bready, 1'b0);
        chk("t6_rst_write_done", o_write_done, 1'b0);
        repeat (2) tick();
        rstn = 1'b1;
        e0 = wr_dones;
        repeat (4) tick();
        chk("t6_no_done_after_rst", wr_dones - e0, 0);
        chk("t6_idle_wvalid", m_wvalid, 1'b0);
        r0 = wr_reqs;
        i_num_trans = 18'd4; i_write_addr = 32'h0000_8000; i_ctrl_write = 1'b1;
        tick();
        i_ctrl_write = 1'b0;
        wr_slave(0, 4, 0, 2'b00, 1'b0, -1, 32'h0000_8000, 32'h4400_0000);
        chk("t6_new_reqs", wr_reqs - r0, 4);
        chk("t6_new_done", wr_dones - e0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
